// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall/flush sequencer for a 5-stage pipeline. Handles three
//   hazards: data-memory wait states (req/ready handshake with a timeout
//   abort), load-use dependencies and taken-branch redirects.
//   The controller is pure control logic with no datapath.
//
// Optional feature: define PERF_CNT_EN to build a saturating counter of
//   stall_pc cycles. Without it, stall_cnt is tied to 0.
//
// Parameters
//   MEM_TIMEOUT  max cycles spent stalled on memory before abort (2..255)
//   CNT_W        width of stall_cnt
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   id_rs1, id_rs2            source registers of the instruction in ID
//   ex_rd, ex_memRead         destination / is-load of the instruction in EX
//   ex_branchTaken            EX resolved a taken branch or jump
//   me_memAccess, dmem_ready  ME memory access / memory completes this cycle
//   dmem_req                  request to data memory
//   stall_pc..stall_mewb      hold PC and the four pipeline registers
//   flush_ifid, flush_idex    load a bubble into IF/ID, ID/EX
//   wb_kill, mem_err          abort: suppress writeback, one-cycle error pulse
//   stall_cnt                 stall-cycle counter (PERF_CNT_EN only)
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memRead,
    input  logic             ex_branchTaken,
    input  logic             me_memAccess,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             stall_idex,
    output logic             stall_exme,
    output logic             stall_mewb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             wb_kill,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        ABORT    = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;

    logic mem_miss;
    logic mem_stall;
    logic hazard_ok;
    logic load_use;

    always_comb begin
        mem_miss  = (state == IDLE) && me_memAccess && !dmem_ready;
        mem_stall = mem_miss || ((state == MEM_WAIT) && !dmem_ready);
        // Branch and load-use are also honoured in the cycle a memory wait
        // releases: EX/ME advances then, so a branch held in EX would
        // otherwise be lost.
        hazard_ok = (state != ABORT) && !mem_stall;
        load_use  = ex_memRead && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    end

    // Mealy outputs: a memory miss must stall in the same cycle it is seen.
    always_comb begin
        dmem_req   = 1'b0;
        stall_pc   = 1'b0;
        stall_ifid = 1'b0;
        stall_idex = 1'b0;
        stall_exme = 1'b0;
        stall_mewb = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        wb_kill    = 1'b0;
        mem_err    = 1'b0;
        if (!rst) begin
            dmem_req = (state == IDLE) ? me_memAccess : (state == MEM_WAIT);
            if (mem_stall) begin
                stall_pc   = 1'b1;
                stall_ifid = 1'b1;
                stall_idex = 1'b1;
                stall_exme = 1'b1;
                stall_mewb = 1'b1;
            end
            if (state == ABORT) begin
                wb_kill = 1'b1;
                mem_err = 1'b1;
            end
            if (hazard_ok) begin
                if (ex_branchTaken) begin
                    // Wrong-path dependent instruction: no load-use stall.
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else if (load_use) begin
                    stall_pc   = 1'b1;
                    stall_ifid = 1'b1;
                    flush_idex = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_miss) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state    <= IDLE;
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state    <= ABORT;
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ABORT: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= 8'd0;
                end
            endcase
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] perf_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt <= '0;
        end else if (stall_pc && (perf_cnt != {CNT_W{1'b1}})) begin
            perf_cnt <= perf_cnt + 1'b1;
        end
    end

    assign stall_cnt = perf_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: table of per-cycle vectors applied in
// order (state carries from one row to the next), then a short hand-written
// sequence for the stall counter.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 32;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       ex_rd;
    logic             ex_memRead;
    logic             ex_branchTaken;
    logic             me_memAccess;
    logic             dmem_ready;
    logic             dmem_req;
    logic             stall_pc;
    logic             stall_ifid;
    logic             stall_idex;
    logic             stall_exme;
    logic             stall_mewb;
    logic             flush_ifid;
    logic             flush_idex;
    logic             wb_kill;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT(4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .ex_rd         (ex_rd),
        .ex_memRead    (ex_memRead),
        .ex_branchTaken(ex_branchTaken),
        .me_memAccess  (me_memAccess),
        .dmem_ready    (dmem_ready),
        .dmem_req      (dmem_req),
        .stall_pc      (stall_pc),
        .stall_ifid    (stall_ifid),
        .stall_idex    (stall_idex),
        .stall_exme    (stall_exme),
        .stall_mewb    (stall_mewb),
        .flush_ifid    (flush_ifid),
        .flush_idex    (flush_idex),
        .wb_kill       (wb_kill),
        .mem_err       (mem_err),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output bit order:
    // {dmem_req, stall_pc, stall_ifid, stall_idex, stall_exme, stall_mewb,
    //  flush_ifid, flush_idex, wb_kill, mem_err}
    localparam logic [9:0] O_NONE  = 10'b0_00000_00_00;
    localparam logic [9:0] O_MEMST = 10'b1_11111_00_00;
    localparam logic [9:0] O_REQ   = 10'b1_00000_00_00;
    localparam logic [9:0] O_ABORT = 10'b0_00000_00_11;
    localparam logic [9:0] O_LU    = 10'b0_11000_01_00;
    localparam logic [9:0] O_BR    = 10'b0_00000_11_00;

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       mrd;
        logic       br;
        logic       acc;
        logic       rdy;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   errors;
    int   exp_cnt;

    task automatic add(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic mrd, input logic br,
                       input logic acc, input logic rdy, input logic [9:0] exp);
        vec_t v;
        v.rst = r; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.mrd = mrd;
        v.br = br; v.acc = acc; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst            = v.rst;
        id_rs1         = v.rs1;
        id_rs2         = v.rs2;
        ex_rd          = v.rd;
        ex_memRead     = v.mrd;
        ex_branchTaken = v.br;
        me_memAccess   = v.acc;
        dmem_ready     = v.rdy;
    endtask

    function automatic logic [CNT_W-1:0] cnt_expect(input int n);
`ifdef PERF_CNT_EN
        return CNT_W'(n);
`else
        return '0 + CNT_W'(n - n);
`endif
    endfunction

    logic [9:0] got;

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 0;
        rst = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        ex_memRead = 1'b0; ex_branchTaken = 1'b0;
        me_memAccess = 1'b0; dmem_ready = 1'b0;

        //   rst rs1 rs2 rd  mrd br acc rdy expected
        // reset held with a pending miss: everything forced low
        add(1, 0, 0, 0, 0, 0, 1, 0, O_NONE);
        add(1, 0, 0, 0, 0, 0, 1, 0, O_NONE);
        // first cycle out of reset: IDLE miss stalls immediately
        add(0, 0, 0, 0, 0, 0, 1, 0, O_MEMST);
        add(0, 0, 0, 0, 0, 0, 1, 1, O_REQ);
        // three wait cycles then ready
        add(0, 0, 0, 0, 0, 0, 1, 0, O_MEMST);
        add(0, 0, 0, 0, 0, 0, 1, 0, O_MEMST);
        add(0, 0, 0, 0, 0, 0, 1, 0, O_MEMST);
        add(0, 0, 0, 0, 0, 0, 1, 1, O_REQ);
        // timeout with MEM_TIMEOUT=4: four stall cycles then abort;
        // branch + load-use during ABORT are ignored
        add(0, 0, 0, 0, 0, 0, 1, 0, O_MEMST);
        add(0, 0, 0, 0, 0, 0, 1, 0, O_MEMST);
        add(0, 0, 0, 0, 0, 0, 1, 0, O_MEMST);
        add(0, 0, 0, 0, 0, 0, 1, 0, O_MEMST);
        add(0, 0, 5, 5, 1, 1, 1, 0, O_ABORT);
        add(0, 0, 0, 0, 0, 0, 0, 0, O_NONE);
        // load-use via rs2, rd=0, non-load, via rs1
        add(0, 1, 5, 5, 1, 0, 0, 0, O_LU);
        add(0, 0, 0, 0, 1, 0, 0, 0, O_NONE);
        add(0, 5, 1, 5, 0, 0, 0, 0, O_NONE);
        add(0, 7, 2, 7, 1, 0, 0, 0, O_LU);
        // branch beats load-use
        add(0, 1, 5, 5, 1, 1, 0, 0, O_BR);
        // memory stall beats branch; branch taken on the release cycle
        add(0, 1, 5, 5, 1, 1, 1, 0, O_MEMST);
        add(0, 1, 5, 5, 1, 1, 1, 0, O_MEMST);
        add(0, 1, 5, 5, 1, 1, 1, 1, O_REQ | O_BR);
        // single-cycle access together with load-use
        add(0, 3, 0, 3, 1, 0, 1, 1, O_REQ | O_LU);
        // reset in MEM_WAIT: back to IDLE, no mem_err
        add(0, 0, 0, 0, 0, 0, 1, 0, O_MEMST);
        add(0, 0, 0, 0, 0, 0, 1, 0, O_MEMST);
        add(1, 0, 0, 0, 0, 0, 1, 0, O_NONE);
        add(0, 0, 0, 0, 0, 0, 0, 0, O_NONE);
        add(0, 0, 0, 0, 0, 0, 1, 0, O_MEMST);
        add(0, 0, 0, 0, 0, 0, 1, 1, O_REQ);
        add(0, 0, 0, 0, 0, 0, 0, 0, O_NONE);

        // preamble reset so all registers are defined
        @(posedge clk);
        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            got = {dmem_req, stall_pc, stall_ifid, stall_idex, stall_exme,
                   stall_mewb, flush_ifid, flush_idex, wb_kill, mem_err};
            checks++;
            if (got !== vecs[i].exp) begin
                errors++;
                $display("FAIL vec%0d outputs: got %b expected %b", i, got, vecs[i].exp);
            end
            checks++;
            if (stall_cnt !== cnt_expect(exp_cnt)) begin
                errors++;
                $display("FAIL vec%0d stall_cnt: got %0d expected %0d", i, stall_cnt,
                         cnt_expect(exp_cnt));
            end
            if (vecs[i].rst) exp_cnt = 0;
            else if (vecs[i].exp[8]) exp_cnt++;
        end

        // Stall counter: 3 memory wait cycles + 1 load-use cycle
        @(negedge clk);
        rst = 1'b1; me_memAccess = 1'b0; dmem_ready = 1'b0;
        ex_memRead = 1'b0; ex_branchTaken = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
        @(negedge clk);
        rst = 1'b0; me_memAccess = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        dmem_ready = 1'b1;
        @(negedge clk);
        me_memAccess = 1'b0; dmem_ready = 1'b0;
        ex_memRead = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9;
        @(negedge clk);
        ex_memRead = 1'b0; ex_rd = '0; id_rs1 = '0;
        #1;
        checks++;
        if (stall_cnt !== cnt_expect(4)) begin
            errors++;
            $display("FAIL perf_cnt: got %0d expected %0d", stall_cnt, cnt_expect(4));
        end
        checks++;
        if ({stall_pc, mem_err} !== 2'b00) begin
            errors++;
            $display("FAIL perf_idle: got stall_pc=%b mem_err=%b expected 0 0", stall_pc, mem_err);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
